// File: rtl/serial_comparator.sv
// serial_comparator: bit-serial unsigned magnitude comparator.
// Operands are captured in parallel on the edge that accepts start. The scan
// then walks from the MSB toward the LSB, one bit per clock. The eq/lt/gt
// flags change only on the edge that enters DONE, or on reset.
//
// Handshake: start is honoured on a rising edge whenever the FSM is not in
// SCAN (that is, IDLE or DONE). busy is high for every SCAN cycle. done is a
// single-cycle pulse that carries fresh flags. busy and done are never high
// together. A start seen during SCAN is dropped without side effects.
module serial_comparator #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt,
  output logic [1:0]       state_dbg
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic             diff_found;  // a difference has already been seen in this scan
  logic             rel_gt;      // direction of that first difference (1: a > b)

  logic bit_a;
  logic bit_b;
  logic cur_diff;
  logic last_bit;
  logic finish;
  logic accept;
  logic eff_diff;
  logic eff_gt;

  assign bit_a = a_q[idx];
  assign bit_b = b_q[idx];

  // Per-bit relation, scan-termination and acceptance decode.
  always_comb begin
    cur_diff = bit_a ^ bit_b;
    last_bit = (idx == '0);
    finish   = (EARLY_EXIT && cur_diff) || last_bit;
    accept   = start && (state != SCAN);
    // The relation that the flags should report if the scan finishes on this
    // bit. An earlier difference always wins over the current one.
    eff_diff = diff_found | cur_diff;
    eff_gt   = diff_found ? rel_gt : bit_a;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (finish) state_nxt = DONE_ST;
      DONE_ST: state_nxt = start ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy      = (state == SCAN);
    done      = (state == DONE_ST);
    state_dbg = state;
  end

  // Operand capture, index walk, latched relation and the result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      idx        <= '0;
      diff_found <= 1'b0;
      rel_gt     <= 1'b0;
      eq         <= 1'b0;
      lt         <= 1'b0;
      gt         <= 1'b0;
    end else if (accept) begin
      a_q        <= a;
      b_q        <= b;
      idx        <= IW'(WIDTH - 1);
      diff_found <= 1'b0;
      rel_gt     <= 1'b0;
    end else if (state == SCAN) begin
      if (cur_diff && !diff_found) begin
        diff_found <= 1'b1;
        rel_gt     <= bit_a;
      end
      // The index parks at 0 instead of wrapping.
      if (!last_bit) idx <= idx - 1'b1;
      if (finish) begin
        eq <= ~eff_diff;
        gt <= eff_diff & eff_gt;
        lt <= eff_diff & ~eff_gt;
      end
    end
  end

endmodule

// File: tb/tb_serial_comparator.sv
// tb_serial_comparator: two instances share one clock and one reset.
// Instance 0 uses EARLY_EXIT=1 and instance 1 uses EARLY_EXIT=0.
// Drivers push the expected flags and latency into a per-instance queue.
// A negedge monitor pops and checks on every done pulse, and also checks the
// per-cycle invariants.
module tb_serial_comparator;

  localparam int W  = 8;
  localparam int QW = 32 + 8 + 3;  // {accept cycle, latency, eq/lt/gt}

  logic         clk;
  logic         rst;
  logic         start_s [2];
  logic [W-1:0] a_s     [2];
  logic [W-1:0] b_s     [2];
  logic         busy_s  [2];
  logic         done_s  [2];
  logic         eq_s    [2];
  logic         lt_s    [2];
  logic         gt_s    [2];
  logic [1:0]   dbg_s   [2];

  logic [QW-1:0] exp_q0[$];
  logic [QW-1:0] exp_q1[$];

  int tests;
  int fails;
  int cyc;
  int bcnt [2];
  bit seen [2];
  logic [2:0] prev [2];

  serial_comparator #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_e (
    .clk(clk), .rst(rst), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .eq(eq_s[0]), .lt(lt_s[0]), .gt(gt_s[0]),
    .state_dbg(dbg_s[0])
  );

  serial_comparator #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_n (
    .clk(clk), .rst(rst), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .eq(eq_s[1]), .lt(lt_s[1]), .gt(gt_s[1]),
    .state_dbg(dbg_s[1])
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: relation from integer compare. The latency is WIDTH, or
  // with early exit, WIDTH minus the position of the highest differing bit.
  function automatic logic [10:0] ref_model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                            input bit ee);
    logic [W-1:0] x;
    int m;
    int lat;
    logic [2:0] fl;
    x = av ^ bv;
    if (av == bv)     fl = 3'b100;
    else if (av < bv) fl = 3'b010;
    else              fl = 3'b001;
    lat = W;
    if (ee && x != 0) begin
      m = 0;
      for (int i = 0; i < W; i++) if (x[i]) m = i;
      lat = W - m;
    end
    return {8'(lat), fl};
  endfunction

  task automatic push(input int d, input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [QW-1:0] e;
    e = {32'(cyc), ref_model(av, bv, d == 0)};
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [2:0]    fl;
      logic [QW-1:0] e;
      bit            have;
      fl = {eq_s[d], lt_s[d], gt_s[d]};
      if (rst) begin
        seen[d] = 1'b0;
        bcnt[d] = 0;
        prev[d] = fl;
      end else begin
        if (busy_s[d]) bcnt[d]++;
        check($sformatf("busy_done_excl%0d", d), {31'd0, busy_s[d] & done_s[d]}, 32'd0);
        if (done_s[d]) begin
          have = (d == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
          tests++;
          if (!have) begin
            fails++;
            $display("FAIL unexpected_done%0d: got done=1 expected no pulse at t=%0t", d, $time);
          end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("flags%0d", d), {29'd0, fl}, {29'd0, e[2:0]});
            check($sformatf("latency%0d", d), 32'(cyc - int'(e[42:11])), {24'd0, e[10:3]});
            check($sformatf("busy_cycles%0d", d), 32'(bcnt[d]), {24'd0, e[10:3]});
          end
          bcnt[d] = 0;
          seen[d] = 1'b1;
        end else begin
          check($sformatf("flags_hold%0d", d), {29'd0, fl}, {29'd0, prev[d]});
        end
        if (seen[d]) check($sformatf("onehot%0d", d), {31'd0, $onehot(fl)}, 32'd1);
        prev[d] = fl;
      end
    end
  end

  // Driver tasks
  task automatic wait_done(input int d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_s[d] && n < 40);
    tests++;
    if (!done_s[d]) begin
      fails++;
      $display("FAIL timeout%0d: got no done expected done within 40 cycles", d);
    end
  endtask

  task automatic cmp(input int d, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    start_s[d] = 1'b1; a_s[d] = av; b_s[d] = bv;
    @(posedge clk); #1;
    push(d, av, bv);
    start_s[d] = 1'b0;
    a_s[d] = W'($urandom); b_s[d] = W'($urandom);
    wait_done(d);
  endtask

  // Second operand pair is presented while start stays high through the scan;
  // it must be taken only in the DONE cycle.
  task automatic b2b(input int d, input logic [W-1:0] a1, input logic [W-1:0] b1,
                     input logic [W-1:0] a2, input logic [W-1:0] b2);
    @(negedge clk);
    start_s[d] = 1'b1; a_s[d] = a1; b_s[d] = b1;
    @(posedge clk); #1;
    push(d, a1, b1);
    a_s[d] = a2; b_s[d] = b2;
    wait_done(d);
    @(posedge clk); #1;
    push(d, a2, b2);
    start_s[d] = 1'b0;
    a_s[d] = W'($urandom); b_s[d] = W'($urandom);
    wait_done(d);
  endtask

  task automatic ignore_test(input int d);
    @(negedge clk);
    start_s[d] = 1'b1; a_s[d] = 8'h12; b_s[d] = 8'h13;
    @(posedge clk); #1;
    push(d, 8'h12, 8'h13);
    start_s[d] = 1'b0;
    @(posedge clk);  // E1
    @(posedge clk);  // E2
    @(negedge clk);
    start_s[d] = 1'b1; a_s[d] = 8'hF0; b_s[d] = 8'h0F;
    @(posedge clk); #1;  // E3: must be ignored
    start_s[d] = 1'b0;
    wait_done(d);
    repeat (3) @(negedge clk);  // any stray second done is flagged by the monitor
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_busy%0d", tag, d), {31'd0, busy_s[d]}, 32'd0);
      check($sformatf("%s_done%0d", tag, d), {31'd0, done_s[d]}, 32'd0);
      check($sformatf("%s_flags%0d", tag, d), {29'd0, eq_s[d], lt_s[d], gt_s[d]}, 32'd0);
    end
  endtask

  task automatic rand_cmp(input int d);
    logic [W-1:0] av;
    logic [W-1:0] bv;
    av = W'($urandom);
    case ($urandom_range(0, 3))
      0:       bv = av;
      1:       bv = av ^ (W'(1) << $urandom_range(0, W - 1));
      default: bv = W'($urandom);
    endcase
    cmp(d, av, bv);
  endtask

  // Stimulus sequence and final report
  initial begin
    tests = 0; fails = 0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; a_s[d] = '0; b_s[d] = '0;
      bcnt[d] = 0; seen[d] = 1'b0; prev[d] = 3'b000;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check_all_zero("reset");

    // Early-exit instance: equal, MSB-difference, LSB-difference
    cmp(0, 8'hA5, 8'hA5);
    cmp(0, 8'h80, 8'h7F);
    cmp(0, 8'h12, 8'h13);

    // Full-scan instance: prior lt result must hold until the gt result lands
    cmp(1, 8'h12, 8'h13);
    cmp(1, 8'h80, 8'h00);

    // start during SCAN is dropped
    ignore_test(0);
    ignore_test(1);

    // Reset mid-scan aborts with no done pulse
    @(negedge clk);
    start_s[1] = 1'b1; a_s[1] = 8'h80; b_s[1] = 8'h00;
    @(posedge clk); #1;
    push(1, 8'h80, 8'h00);
    start_s[1] = 1'b0;
    repeat (4) @(posedge clk);  // E4
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    exp_q1.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (12) @(negedge clk);  // a stray done would hit an empty queue
    cmp(1, 8'h01, 8'h02);
    cmp(0, 8'h01, 8'h02);

    // Back-to-back through the DONE cycle
    b2b(0, 8'h12, 8'h13, 8'hFF, 8'h00);
    b2b(1, 8'hA5, 8'hA5, 8'hFF, 8'h00);

    // Randomized compares on both instances
    for (int i = 0; i < 40; i++) begin
      rand_cmp(0);
      rand_cmp(1);
    end
    for (int i = 0; i < 6; i++) begin
      b2b(i % 2, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    end

    repeat (3) @(negedge clk);
    tests++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      fails++;
      $display("FAIL pending_expect: got %0d/%0d left expected 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
